match_event_logger: RTL

- Downstream consumer of the serial sequence detector's one-bit match strobe `z`.
- Timestamps every match with a free-running cycle counter and buffers the timestamps in a small FIFO.
- A host or readout stage drains the FIFO through a valid/ready handshake.
- Also keeps a saturating match count and a sticky overflow flag for matches lost to a full FIFO.

---
 rtl/match_event_logger.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/match_event_logger.sv
// match_event_logger
// Timestamps every cycle on which the detector's match strobe `z` is high,
// buffers the timestamps in a small first-word-fall-through FIFO, and keeps
// a saturating match count plus a sticky flag for matches lost to a full FIFO.
// All outputs come from registered state only; `z` never reaches an output
// combinationally.
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     z,
  input  logic                     clr,
  output logic                     ev_valid,
  output logic [TS_W-1:0]          ev_ts,
  input  logic                     ev_ready,
  output logic [CNT_W-1:0]         match_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  // Address width of the storage array; pointers carry one extra wrap bit so
  // that full (same index, different lap) and empty (identical) never alias.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TS_W-1:0]  ts_cnt_q,      ts_cnt_d;
  logic [PW-1:0]    wr_ptr_q,      wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic             overflow_q,    overflow_d;

  // Timestamp storage and its write port.
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [TS_W-1:0]  mem_wdata;

  // ---------------------------------------------------------------------------
  // FIFO status derived from the pointers
  // ---------------------------------------------------------------------------
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          do_drop;
  logic [PW-1:0] occupancy;

  // Decode occupancy and the push / pop / drop decisions for this edge.
  always_comb begin
    occupancy  = wr_ptr_q - rd_ptr_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop only happens when an entry is actually presented; ev_ready while
    // empty is ignored, and a match arriving into an empty FIFO is not
    // bypassed to the output in the same cycle.
    do_pop  = !fifo_empty && ev_ready;

    // When full, a simultaneous pop frees the slot the new match needs, so
    // the match is only lost when full and not popping.
    do_push = z && (!fifo_full || do_pop);
    do_drop = z && fifo_full && !do_pop;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; clr has priority over every other event
  // ---------------------------------------------------------------------------

  // Compute next values for the counter, pointers, match count and overflow.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    ts_cnt_d      = ts_cnt_q + TS_W'(1);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    match_count_d = match_count_q;
    overflow_d    = overflow_q;

    if (clr) begin
      ts_cnt_d      = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      match_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Every sampled match counts, including ones dropped on a full FIFO.
      if (z && (match_count_q != CNT_MAX)) begin
        match_count_d = match_count_q + CNT_W'(1);
      end
      if (do_drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Storage write port: the stored value is the counter before this edge's
  // increment, i.e. the cycle number at which the match was sampled.
  always_comb begin
    mem_we    = do_push && !clr;
    mem_waddr = wr_ptr_q[AW-1:0];
    mem_wdata = ts_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control state: cleared asynchronously, updated on each rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      ts_cnt_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      match_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      ts_cnt_q      <= ts_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      match_count_q <= match_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Timestamp storage: written on push only.
  // NOTE: the array is deliberately not reset; reset empties the FIFO through
  // the pointers, and stale contents are masked from ev_ts while empty.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // First-word fall-through head presentation and status outputs.
  always_comb begin
    ev_valid    = !fifo_empty;
    ev_ts       = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    level       = occupancy;
    match_count = match_count_q;
    overflow    = overflow_q;
  end

endmodule
